pulse_period_checker: RTL

PULSE_PERIOD_CHECKER -- requirements
Module: pulse_period_checker

---
 rtl/ppc_pkg.sv | 24 ++
 rtl/ppc_interval_counter.sv | 60 ++++++
 rtl/pulse_period_checker.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ppc_pkg.sv
// rtl/ppc_pkg.sv - shared types and defaults for the pulse period checker
// Purpose: state encoding, default parameter values and a width helper used
//          by pulse_period_checker and ppc_interval_counter.
// Ports:   none (package).
package ppc_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } ppc_state_e;

  localparam int PPC_PERIOD_DEFAULT   = 5001;
  localparam int PPC_TOL_DEFAULT      = 0;
  localparam int PPC_CBITS_DEFAULT    = 13;
  localparam int PPC_LOCK_CNT_DEFAULT = 2;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int ppc_cnt_bits(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ppc_interval_counter.sv
// rtl/ppc_interval_counter.sv - saturating pulse interval counter with late detect
// Purpose: counts cycles since the last sig_in pulse and flags the cycle on
//          which the count reaches LATE_AT without a pulse, once per interval.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   sig_in_i     in   pulse under check; restarts the interval
//   cnt_o        out  registered interval count (0 after reset, 1 after a pulse)
//   late_hit_o   out  combinational: count == LATE_AT with no pulse this cycle
module ppc_interval_counter
  import ppc_pkg::*;
#(
  parameter int               CBITS   = PPC_CBITS_DEFAULT,
  parameter logic [CBITS-1:0] LATE_AT = CBITS'(PPC_PERIOD_DEFAULT + PPC_TOL_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in_i,
  output logic [CBITS-1:0] cnt_o,
  output logic             late_hit_o
);

  localparam logic [CBITS-1:0] CNT_MAX = '1;

  logic [CBITS-1:0] cnt_q, cnt_d;
  // Remembers that late already fired this interval, so a count parked at
  // LATE_AT (when LATE_AT equals the saturation value) cannot re-trigger it.
  logic             fired_q, fired_d;

  always_comb begin
    cnt_d      = cnt_q;
    fired_d    = fired_q;
    late_hit_o = 1'b0;
    if (sig_in_i) begin
      cnt_d   = CBITS'(1);
      fired_d = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CBITS'(1);
      end
      if ((cnt_q == LATE_AT) && !fired_q) begin
        late_hit_o = 1'b1;
        fired_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pulse_period_checker.sv
// rtl/pulse_period_checker.sv - lock/fault tracking of a periodic single-cycle pulse
// Purpose: hunts for a pulse train of period PERIOD (+/- TOL), locks after
//          LOCK_CNT good intervals and reports early/late intervals.
// Optional build: define PULSE_PERIOD_CHECKER_STATS_EN to add fault_cnt.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (wins over sig_in)
//   sig_in     in   periodic single-cycle pulse under check
//   locked     out  high while in LOCKED
//   early      out  one-cycle pulse, interval shorter than PERIOD-TOL
//   late       out  one-cycle pulse, no pulse by PERIOD+TOL
//   err        out  sticky, early/late seen while LOCKED
//   gap        out  current interval count (saturating)
//   fault_cnt  out  [STATS_EN only] saturating count of early+late outside HUNT
module pulse_period_checker
  import ppc_pkg::*;
#(
  parameter int PERIOD   = PPC_PERIOD_DEFAULT,
  parameter int TOL      = PPC_TOL_DEFAULT,
  parameter int CBITS    = PPC_CBITS_DEFAULT,
  parameter int LOCK_CNT = PPC_LOCK_CNT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             locked,
  output logic             early,
  output logic             late,
  output logic             err,
  output logic [CBITS-1:0] gap
`ifdef PULSE_PERIOD_CHECKER_STATS_EN
  ,
  output logic [7:0]       fault_cnt
`endif
);

  if (((longint'(PERIOD) + longint'(TOL)) >= (longint'(1) << CBITS)) ||
      (TOL >= PERIOD) || (TOL < 0) || (LOCK_CNT < 1)) begin : g_bad_params
    $error("pulse_period_checker: need PERIOD+TOL < 2**CBITS, 0 <= TOL < PERIOD, LOCK_CNT >= 1");
  end

  localparam int               GBITS       = ppc_cnt_bits(LOCK_CNT);
  localparam logic [CBITS-1:0] LO          = CBITS'(PERIOD - TOL);
  localparam logic [CBITS-1:0] HI          = CBITS'(PERIOD + TOL);
  localparam logic [GBITS-1:0] LOCK_TARGET = GBITS'(LOCK_CNT);

  ppc_state_e       state_q, state_d;
  logic [GBITS-1:0] good_q, good_d;
  logic             early_q, early_d;
  logic             late_q, late_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic [CBITS-1:0] cnt;
  logic             late_hit;
  logic             is_early;
  logic             is_good;

  ppc_interval_counter #(
    .CBITS  (CBITS),
    .LATE_AT(HI)
  ) u_interval_counter (
    .clk       (clk),
    .rst       (rst),
    .sig_in_i  (sig_in),
    .cnt_o     (cnt),
    .late_hit_o(late_hit)
  );

  // Classify the interval closed by this cycle's pulse. A pulse after late has
  // cnt > HI and is neither early nor good: it simply starts a new interval.
  assign is_early = sig_in && (cnt < LO);
  assign is_good  = sig_in && (cnt >= LO) && (cnt <= HI);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = err_q;
    early_d = 1'b0;
    late_d  = 1'b0;

    case (state_q)
      HUNT: begin
        if (sig_in) begin
          state_d = SYNC;
          good_d  = '0;
        end
      end
      SYNC: begin
        if (is_early || late_hit) begin
          state_d = HUNT;
          good_d  = '0;
        end else if (is_good) begin
          good_d = good_q + GBITS'(1);
          if (good_d == LOCK_TARGET) begin
            state_d = LOCKED;
          end
        end else if (sig_in) begin
          // Overlong interval without a late (not reachable normally): restart.
          good_d = '0;
        end
      end
      LOCKED: begin
        if (is_early || late_hit) begin
          state_d = FAULT;
          err_d   = 1'b1;
        end else if (sig_in && !is_good) begin
          state_d = SYNC;
          good_d  = '0;
        end
      end
      FAULT: begin
        if (sig_in) begin
          state_d = SYNC;
          good_d  = '0;
        end
      end
      default: begin
        state_d = HUNT;
        good_d  = '0;
      end
    endcase

    if (state_q != HUNT) begin
      early_d = is_early;
      late_d  = late_hit;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      good_q   <= '0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      early_q  <= early_d;
      late_q   <= late_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign locked = locked_q;
  assign early  = early_q;
  assign late   = late_q;
  assign err    = err_q;
  assign gap    = cnt;

`ifdef PULSE_PERIOD_CHECKER_STATS_EN
  logic [7:0] fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if ((state_q != HUNT) && (is_early || late_hit) && (fault_q != 8'hFF)) begin
      fault_d = fault_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= '0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_cnt = fault_q;
`endif

endmodule
